peripheral_mpram_ahb3_ctrl: RTL
===============================

PERIPHERAL_MPRAM_AHB3_CTRL -- requirements
Module: peripheral_mpram_ahb3_ctrl

Interface
REQ-001 SHALL have parameter ABITS, default 10, memory word-address width.
REQ-002 SHALL have parameter DBITS, default 32, bus/memory data width (multiple of 8).
REQ-003 SHALL have parameter HADDR_SIZE, default 32, AHB address width.
REQ-004 SHALL have port clk_i input 1, the single clock, all logic on its rising edge.
REQ-005 SHALL have port rst_i input 1, reset, synchronous, active-high.
REQ-006 SHALL have AHB-Lite slave inputs: hsel_i 1, haddr_i HADDR_SIZE, hwdata_i DBITS, hwrite_i 1, hsize_i 3, hburst_i 3, hprot_i 4, htrans_i 2, hmastlock_i 1, hready_i 1.
REQ-007 SHALL have AHB-Lite slave outputs: hrdata_o DBITS, hreadyout_o 1, hresp_o 1.
REQ-008 SHALL have memory write outputs: mem_waddr_o ABITS, mem_din_o DBITS, mem_we_o 1, mem_be_o (DBITS+7)/8.
REQ-009 SHALL have memory read port: mem_raddr_o ABITS output; mem_dout_i DBITS input (registered, 1-cycle latency, no write-to-read bypass).

Function
REQ-010 Transfer accepted when hsel_i & hready_i & htrans_i in {NONSEQ, SEQ}; IDLE/BUSY get zero-wait OKAY, no memory access.
REQ-011 Word address = haddr_i[ABITS+log2(DBITS/8)-1 : log2(DBITS/8)]; upper bits ignored (aliasing/wrap).
REQ-012 Byte enables derived from hsize_i and haddr_i low bits; natural alignment required.
REQ-013 hsize_i larger than DBITS, or misaligned address, SHALL yield two-cycle ERROR: cycle 1 hresp_o=1 hreadyout_o=0, cycle 2 hresp_o=1 hreadyout_o=1; no memory write.
REQ-014 Write: address phase registered; in data phase mem_we_o=1, mem_waddr_o=registered address, mem_be_o=registered enables, mem_din_o=hwdata_i; zero wait states.
REQ-015 Read: mem_raddr_o driven combinationally from haddr_i in address phase; hrdata_o=mem_dout_i in data phase; zero wait states.
REQ-016 Hazard: read accepted while a write data phase targets the same word SHALL insert exactly one wait state (hreadyout_o=0), with mem_raddr_o held at the registered read address, so returned data includes the write.
REQ-017 While hreadyout_o=0, mem_raddr_o SHALL come from the registered address, never haddr_i.
REQ-018 Write-then-read to a different word SHALL complete with no wait state.
REQ-019 FSM states: IDLE, DATA, STALL, ERR1, ERR2; IDLE/DATA->STALL on hazard; STALL->DATA/IDLE next cycle; any->ERR1 on illegal accept; ERR1->ERR2->IDLE.
REQ-020 hburst_i, hprot_i, hmastlock_i SHALL be ignored; bursts handled as individual beats.
REQ-021 mem_we_o SHALL never assert in ERR1, ERR2, STALL or IDLE.

Reset
REQ-022 While rst_i=1: state IDLE, hreadyout_o=1, hresp_o=0, mem_we_o=0, mem_be_o=0, registered address/control cleared.
REQ-023 Reset asserted mid-transfer SHALL abandon the transfer; no pending write reaches memory.
REQ-024 hrdata_o has no reset requirement beyond reflecting mem_dout_i.

Structure
REQ-025 Package peripheral_mpram_ahb3_pkg SHALL hold HTRANS, HSIZE, HRESP constants and the FSM state enum.
REQ-026 Sub-module peripheral_mpram_ahb3_be_gen SHALL compute byte enables and misalignment flag from hsize/haddr.
REQ-027 Block SHALL connect directly to peripheral_mpram_1r1w-style memory ports without glue.

Verification (DBITS=32, ABITS=10, behavioural 1R1W memory model)
REQ-028 rst_i=1 for 2 cycles -> hreadyout_o=1, hresp_o=0, mem_we_o=0, mem_be_o=0.
REQ-029 Word write 0x10 data 0xDEADBEEF, then read 0x10 two cycles later -> hrdata_o=0xDEADBEEF, no wait states.
REQ-030 Byte write hsize=0 haddr=0x13 hwdata=0xAA000000 -> mem_be_o=4'b1000; read 0x10 -> 0xAAADBEEF.
REQ-031 Write 0x20 data 0x12345678 immediately followed by read 0x20 -> one cycle hreadyout_o=0, then hrdata_o=0x12345678.
REQ-032 hsize=3'b011 write at 0x40 -> ERR1 then ERR2 response, mem_we_o stays 0, memory at 0x40 unchanged.
REQ-033 rst_i asserted during write data phase to 0x50 -> mem_we_o=0 that cycle; memory at 0x50 unchanged.

Source files
------------

// File: rtl/peripheral_mpram_ahb3_pkg.sv
// Shared AHB-Lite encodings and controller FSM states for the multi-port RAM AHB3 front end.
package peripheral_mpram_ahb3_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_BYTE  = 3'b000;
  localparam logic [2:0] HSIZE_HWORD = 3'b001;
  localparam logic [2:0] HSIZE_WORD  = 3'b010;
  localparam logic [2:0] HSIZE_DWORD = 3'b011;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DATA,
    ST_STALL,
    ST_ERR1,
    ST_ERR2
  } state_e;

endpackage

// File: rtl/peripheral_mpram_ahb3_be_gen.sv
// Byte-enable generator: maps hsize/low address bits onto lane enables and flags
// transfers that are wider than the bus or not naturally aligned.
module peripheral_mpram_ahb3_be_gen
  import peripheral_mpram_ahb3_pkg::*;
#(
  parameter  int DBITS = 32,
  localparam int NB    = (DBITS + 7) / 8,
  localparam int AW    = (NB > 1) ? $clog2(NB) : 1
) (
  input  logic [2:0]    hsize_i,
  input  logic [AW-1:0] addr_i,
  output logic [NB-1:0] be_o,
  output logic          err_o
);

  localparam int LSB = (NB > 1) ? $clog2(NB) : 0;

  int   nbytes;
  int   off;
  logic too_big;
  logic misalign;

  always_comb begin
    nbytes   = 32'd1 << hsize_i;
    off      = (NB > 1) ? int'(addr_i) : 0;
    too_big  = int'(hsize_i) > LSB;
    misalign = (off & (nbytes - 1)) != 0;
    err_o    = too_big | misalign;
    be_o     = '0;
    for (int i = 0; i < NB; i++)
      be_o[i] = !err_o && (i >= off) && (i < off + nbytes);
  end

endmodule

// File: rtl/peripheral_mpram_ahb3_ctrl.sv
// AHB-Lite slave front end for a 1R1W RAM: zero-wait reads/writes, one stall on a
// read-after-write to the same word, and two-cycle ERROR for illegal size/alignment.
module peripheral_mpram_ahb3_ctrl
  import peripheral_mpram_ahb3_pkg::*;
#(
  parameter int ABITS      = 10,
  parameter int DBITS      = 32,
  parameter int HADDR_SIZE = 32
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    hsel_i,
  input  logic [HADDR_SIZE-1:0]   haddr_i,
  input  logic [DBITS-1:0]        hwdata_i,
  input  logic                    hwrite_i,
  input  logic [2:0]              hsize_i,
  input  logic [2:0]              hburst_i,
  input  logic [3:0]              hprot_i,
  input  logic [1:0]              htrans_i,
  input  logic                    hmastlock_i,
  input  logic                    hready_i,
  output logic [DBITS-1:0]        hrdata_o,
  output logic                    hreadyout_o,
  output logic                    hresp_o,
  output logic [ABITS-1:0]        mem_waddr_o,
  output logic [DBITS-1:0]        mem_din_o,
  output logic                    mem_we_o,
  output logic [(DBITS+7)/8-1:0]  mem_be_o,
  output logic [ABITS-1:0]        mem_raddr_o,
  input  logic [DBITS-1:0]        mem_dout_i
);

  localparam int NB  = (DBITS + 7) / 8;
  localparam int LSB = (NB > 1) ? $clog2(NB) : 0;
  localparam int AW  = (NB > 1) ? $clog2(NB) : 1;

  state_e           state_q, state_d;
  logic [ABITS-1:0] addr_q, addr_d;
  logic [NB-1:0]    be_q, be_d;
  logic             wr_q, wr_d;

  logic [ABITS-1:0] haddr_word;
  logic [NB-1:0]    be_w;
  logic             size_err;
  logic             accept;
  logic             illegal;
  logic             wr_dphase;
  logic             hazard;

  // burst/protection/lock qualifiers carry no meaning for a flat RAM
  logic unused_sig;
  assign unused_sig = ^{hburst_i, hprot_i, hmastlock_i, haddr_i[HADDR_SIZE-1:ABITS+LSB]};

  assign haddr_word = haddr_i[ABITS+LSB-1:LSB];

  peripheral_mpram_ahb3_be_gen #(.DBITS(DBITS)) u_be_gen (
    .hsize_i (hsize_i),
    .addr_i  (haddr_i[AW-1:0]),
    .be_o    (be_w),
    .err_o   (size_err)
  );

  assign accept    = hsel_i & hready_i &
                     ((htrans_i == HTRANS_NONSEQ) | (htrans_i == HTRANS_SEQ));
  assign illegal   = accept & size_err;
  assign wr_dphase = (state_q == ST_DATA) & wr_q;
  // memory has no bypass, so a read of the word being written must re-issue a cycle later
  assign hazard    = accept & ~size_err & ~hwrite_i & wr_dphase & (haddr_word == addr_q);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      be_q    <= '0;
      wr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      be_q    <= be_d;
      wr_q    <= wr_d;
    end
  end

  always_comb begin
    addr_d = addr_q;
    be_d   = be_q;
    wr_d   = wr_q;
    if (accept && !size_err) begin
      addr_d = haddr_word;
      be_d   = be_w;
      wr_d   = hwrite_i;
    end else if (hready_i) begin
      wr_d   = 1'b0;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_STALL: state_d = ST_DATA;
      ST_ERR1:  state_d = ST_ERR2;
      default: begin
        if (illegal)     state_d = ST_ERR1;
        else if (hazard) state_d = ST_STALL;
        else if (accept) state_d = ST_DATA;
        else             state_d = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    hreadyout_o = 1'b1;
    hresp_o     = HRESP_OKAY;
    mem_we_o    = 1'b0;
    mem_be_o    = '0;
    if (!rst_i) begin
      case (state_q)
        ST_STALL: hreadyout_o = 1'b0;
        ST_ERR1: begin
          hreadyout_o = 1'b0;
          hresp_o     = HRESP_ERROR;
        end
        ST_ERR2:  hresp_o = HRESP_ERROR;
        ST_DATA: begin
          mem_we_o = wr_q;
          mem_be_o = wr_q ? be_q : '0;
        end
        default: ;
      endcase
    end
  end

  assign mem_waddr_o = addr_q;
  assign mem_din_o   = hwdata_i;
  assign mem_raddr_o = hreadyout_o ? haddr_word : addr_q;
  assign hrdata_o    = mem_dout_i;

endmodule
